sort_result_buffer: RTL and testbench
=====================================

Name: sort_result_buffer

Overview:
- Downstream stage of the sorter datapath; captures the ascending word stream on `sorted` while `done` is high.
- Stores the words in a small FIFO and re-issues them on a valid/ready output port with a per-run last tag.
- Lets the sort result be drained by a consumer that may stall.
- Optionally checks that each run is non-decreasing (signed compare).

Parameters:
SIZE, 8, words per sort run; sets the last tag; must be >= 2
DEPTH, 8, FIFO depth in words; power of 2, >= 2

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
clr  input  1  synchronous clear: empties the FIFO, zeroes the run counter, clears order_err
done  input  1  sorter finished; input accepted only while high
in_valid  input  1  upstream word strobe, one word per cycle
in_ready  output  1  buffer can accept a word (= !full)
sorted  input  32  sorted word, signed two's complement
out_valid  output  1  FIFO not empty
out_ready  input  1  consumer accepts out_data
out_data  output  32  head-of-FIFO word
out_last  output  1  head word is the last of its run
count  output  $clog2(DEPTH)+1  words currently stored
order_err  output  1  sticky: a run was not non-decreasing

Behaviour:
- Reset (rst=1, asynchronous):
  - Write and read pointers, count, and run counter go to 0.
  - order_err=0, out_valid=0, in_ready=1.
  - FIFO storage contents are don't-care.
- Pointers are $clog2(DEPTH)+1 bits and wrap naturally.
  - full = MSBs differ and low bits equal; empty = pointers equal.
- Push occurs when done && in_valid && in_ready.
  - Stores {tag, sorted} at the write pointer, then increments the write pointer.
  - tag = (run_cnt == SIZE-1).
  - run_cnt increments on each push and wraps from SIZE-1 to 0.
- Pop occurs when out_valid && out_ready; increments the read pointer.
- out_data and out_last come combinationally from storage at the read pointer, so a pushed word appears on out_data the cycle after the push.
- count tracks pushes and pops:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
- in_valid while done=0:
  - Ignored; no push, run_cnt held.
  - in_ready still reflects !full.
- Full: in_ready=0 and the push is refused even if a pop occurs in the same cycle (no full bypass). Upstream must hold the word.
- Empty: out_valid=0; out_data is don't-care. There is no empty bypass: a push in an empty cycle is visible next cycle.
- clr=1:
  - Takes effect at the next clock edge.
  - Has priority over push and pop in that cycle; a word offered in that cycle is dropped.
- done falling mid-run: run_cnt is retained, and the run continues when done rises again. Upstream uses clr to abandon a partial run.
- rst mid-operation: all stored words are discarded immediately.

Optional Feature:
- Macro SORT_ORDER_CHECK_EN.
- Defined:
  - A 32-bit prev register loads `sorted` on every push.
  - On a push with run_cnt != 0 and $signed(sorted) < $signed(prev), order_err is set the next cycle.
  - order_err is cleared only by rst or clr.
  - Equal words are legal.
- Not defined: order_err is tied to 0 and no prev register exists.

Test Plan:
1. Basic drain (SIZE=8, DEPTH=8):
   - Stimulus: rst, then done=1 and push -5, -1, 0, 3, 3, 7, 20, 100 on consecutive cycles with out_ready=0.
   - Required: count=8, in_ready=0.
   - Then raise out_ready: out_data sequence is -5 through 100, out_last=1 only on 100, and count returns to 0.
2. Full with simultaneous pop:
   - Stimulus: FIFO full, then in_valid=1 and out_ready=1 in the same cycle.
   - Required: one pop, no push, count=7; the next cycle the push is accepted and count returns to 8.
3. Gated by done:
   - Stimulus: done=0, in_valid=1 for 4 cycles.
   - Required: count=0, run_cnt=0.
   - Then done=1 with 2 pushes: count=2, neither word tagged last.
4. Order check (SORT_ORDER_CHECK_EN):
   - Stimulus: run 1, 2, 5, 4, ...
   - Required: order_err=1 on the cycle after the push of 4 and stays high.
   - Stimulus: clr pulse. Required: order_err=0 and count=0.
   - Run boundary: a run ending in 100 followed by a run starting with -3 must not set order_err.
5. Async reset mid-run:
   - Stimulus: 5 words stored, rst asserted between clock edges.
   - Required: out_valid=0 and count=0 immediately, in_ready=1.
   - Then push 8 words: out_last is set on the 8th.
6. Stall/backpressure interleave:
   - Stimulus: out_ready toggles 1,0,1,0 while 16 words (two runs) stream in.
   - Required: all 16 words are output in order, out_last is set on words 8 and 16, and no word is lost or duplicated.

Source files
------------

// File: rtl/sort_result_buffer_if.sv
// Handshake bundle around sort_result_buffer.
// The upstream side carries done/in_valid/sorted/in_ready. The downstream side carries out_valid/out_ready/out_data/out_last.
interface sort_result_buffer_if;
  logic        done;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] sorted;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  // The buffer's own view of the bundle.
  modport slave (
    input  done, in_valid, sorted, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  // The view of the surrounding logic that feeds and drains the buffer.
  modport master (
    output done, in_valid, sorted, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/sort_result_buffer.sv
// Captures a sorted word stream into a FIFO and replays it on valid/ready with a per-run last tag.
// Optional macro SORT_ORDER_CHECK_EN adds a sticky signed non-decreasing order check per run.
module sort_result_buffer #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  sort_result_buffer_if.slave     bus,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    order_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(SIZE);
  localparam logic [RW-1:0] RUN_LAST = RW'(SIZE - 1);

  logic [32:0]   mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [RW-1:0] run_cnt_q, run_cnt_d;
  logic          full, empty, push, pop, tag;

  always_comb begin
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty = (wr_ptr_q == rd_ptr_q);
    // A full FIFO refuses the word even while it pops in the same cycle.
    push  = bus.done && bus.in_valid && !full && !clr;
    pop   = !empty && bus.out_ready && !clr;
    tag   = (run_cnt_q == RUN_LAST);
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    run_cnt_d = run_cnt_q;
    if (clr) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      run_cnt_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d  = wr_ptr_q + 1'b1;
        run_cnt_d = tag ? '0 : run_cnt_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      run_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {tag, bus.sorted};
  end

  assign count         = wr_ptr_q - rd_ptr_q;
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_data  = mem_q[rd_ptr_q[AW-1:0]][31:0];
  assign bus.out_last  = mem_q[rd_ptr_q[AW-1:0]][32];

`ifdef SORT_ORDER_CHECK_EN
  logic [31:0] prev_q, prev_d;
  logic        order_err_q, order_err_d;

  // The first word of a run is never compared, so run boundaries may step downward.
  always_comb begin
    prev_d      = push ? bus.sorted : prev_q;
    order_err_d = clr ? 1'b0
                : order_err_q | (push && (run_cnt_q != '0) &&
                                 ($signed(bus.sorted) < $signed(prev_q)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q      <= '0;
      order_err_q <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      order_err_q <= order_err_d;
    end
  end

  assign order_err = order_err_q;
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_result_buffer.sv
// Directed bench for sort_result_buffer (SIZE=8, DEPTH=8).
// The order checks expect the order error only when SORT_ORDER_CHECK_EN is defined.
module tb_sort_result_buffer;

`ifdef SORT_ORDER_CHECK_EN
  localparam bit ORDER_EN = 1'b1;
`else
  localparam bit ORDER_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic [3:0] count;
  logic       order_err;
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [31:0] exp_q[$];

  sort_result_buffer_if bus();

  sort_result_buffer #(.SIZE(8), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .bus       (bus),
    .count     (count),
    .order_err (order_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one word with done high. The caller is responsible for ensuring the word is accepted.
  task automatic push_one(input logic [31:0] v);
    bus.done     = 1'b1;
    bus.in_valid = 1'b1;
    bus.sorted   = v;
    exp_q.push_back(v);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int n, input int last_at);
    bus.out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_data"}, bus.out_data, exp_q[0]);
      check({tag, "_last"}, 32'(bus.out_last), 32'(i == last_at));
      void'(exp_q.pop_front());
      step();
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] t1 [8];
    logic [31:0] v16 [16];
    int in_idx;
    int out_idx;
    int cyc;
    logic acc_push;
    logic acc_pop;

    t1 = '{-32'sd5, -32'sd1, 32'sd0, 32'sd3, 32'sd3, 32'sd7, 32'sd20, 32'sd100};
    bus.done = 1'b0;
    bus.in_valid = 1'b0;
    bus.sorted = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_order_err", 32'(order_err), 32'd0);
    rst = 1'b0;
    step();

    // 1. Basic drain
    for (int i = 0; i < 8; i++) push_one(t1[i]);
    check("t1_count_full", 32'(count), 32'd8);
    check("t1_in_ready", 32'(bus.in_ready), 32'd0);
    check("t1_order_err", 32'(order_err), 32'd0);
    drain("t1", 8, 7);
    check("t1_count_empty", 32'(count), 32'd0);
    check("t1_out_valid", 32'(bus.out_valid), 32'd0);

    // 2. Full with simultaneous pop: the offered word is refused
    for (int i = 0; i < 8; i++) push_one(32'(10 + i));
    bus.in_valid  = 1'b1;
    bus.sorted    = 32'd99;
    bus.out_ready = 1'b1;
    step();
    void'(exp_q.pop_front());
    check("t2_count_after_pop", 32'(count), 32'd7);
    check("t2_head", bus.out_data, 32'd11);
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    check("t2_count_refill", 32'(count), 32'd8);
    do_clr();
    check("t2_clr_count", 32'(count), 32'd0);

    // 3. Gated by done, including a done drop mid-run
    bus.done     = 1'b0;
    bus.in_valid = 1'b1;
    bus.sorted   = 32'd77;
    repeat (4) step();
    check("t3_gated_count", 32'(count), 32'd0);
    push_one(32'd5);
    push_one(32'd6);
    check("t3_count2", 32'(count), 32'd2);
    bus.done     = 1'b0;
    bus.in_valid = 1'b1;
    repeat (2) step();
    bus.in_valid = 1'b0;
    check("t3_count_held", 32'(count), 32'd2);
    drain("t3a", 2, -1);
    for (int i = 0; i < 6; i++) push_one(32'(7 + i));
    check("t3_count6", 32'(count), 32'd6);
    drain("t3b", 6, 5);

    // 4. Order check, clear and run boundary
    do_clr();
    bus.out_ready = 1'b1;
    push_one(32'd1);
    push_one(32'd2);
    push_one(32'd5);
    check("t4_err_before", 32'(order_err), 32'd0);
    push_one(32'd4);
    check("t4_err_set", 32'(order_err), 32'(ORDER_EN));
    push_one(32'd6);
    push_one(32'd7);
    check("t4_err_sticky", 32'(order_err), 32'(ORDER_EN));
    bus.in_valid = 1'b1;
    bus.sorted   = 32'd55;
    do_clr();
    bus.in_valid = 1'b0;
    check("t4_clr_err", 32'(order_err), 32'd0);
    check("t4_clr_count", 32'(count), 32'd0);
    check("t4_clr_valid", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 7; i++) push_one(32'(-10 + 3 * i));
    push_one(32'd100);
    push_one(-32'sd3);
    step();
    check("t4_boundary_err", 32'(order_err), 32'd0);
    bus.out_ready = 1'b0;
    do_clr();

    // 5. Asynchronous reset between clock edges
    for (int i = 0; i < 5; i++) push_one(32'(40 + i));
    check("t5_count5", 32'(count), 32'd5);
    #3 rst = 1'b1;
    #1;
    check("t5_rst_valid", 32'(bus.out_valid), 32'd0);
    check("t5_rst_count", 32'(count), 32'd0);
    check("t5_rst_ready", 32'(bus.in_ready), 32'd1);
    #2 rst = 1'b0;
    exp_q.delete();
    step();
    for (int i = 0; i < 8; i++) push_one(32'(200 + i));
    check("t5_count8", 32'(count), 32'd8);
    drain("t5", 8, 7);

    // 6. Two runs streamed under toggling backpressure
    for (int i = 0; i < 16; i++) v16[i] = 32'(-20 + 3 * (i % 8) + 50 * (i / 8));
    in_idx  = 0;
    out_idx = 0;
    cyc     = 0;
    bus.done = 1'b1;
    while (out_idx < 16 && cyc < 300) begin
      bus.in_valid  = (in_idx < 16);
      bus.sorted    = (in_idx < 16) ? v16[in_idx] : 32'd0;
      bus.out_ready = (cyc % 2 == 0);
      #1;
      acc_push = bus.in_valid && bus.in_ready;
      acc_pop  = bus.out_valid && bus.out_ready;
      if (acc_pop) begin
        check("t6_data", bus.out_data, v16[out_idx]);
        check("t6_last", 32'(bus.out_last), 32'(out_idx % 8 == 7));
        out_idx++;
      end
      if (acc_push) in_idx++;
      step();
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("t6_all_out", 32'(out_idx), 32'd16);
    check("t6_all_in", 32'(in_idx), 32'd16);
    check("t6_count_end", 32'(count), 32'd0);
    check("t6_order_err", 32'(order_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
